sdram_host_bridge: RTL and testbench

//  Host-side front end that feeds the SDRAM controller's host interface (addr/data/enable/busy).

---
 rtl/sdram_host_bridge.sv | 132 +++++++++++++
 tb/tb_sdram_host_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_bridge.sv
// Host front end for the SDRAM controller: buffers writes in a FIFO, serialises
// writes/reads into single-cycle controller enables and returns read data as a pulse.
module sdram_host_bridge #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BUSY_TMO   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wr_data,
    output logic              ctl_wr_enable,
    output logic              ctl_rd_enable,
    input  logic              ctl_busy,
    input  logic [DATA_W-1:0] ctl_rd_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic              tmo_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [LW-1:0]     wptr, rptr, count;
    logic [TW-1:0]     tmo_cnt;
    logic              is_rd;
    logic              push, pop, rd_acc, tmo_hit, done;

    // Ready outputs are held low while reset is asserted.
    always_comb begin
        wr_req_ready = rst_n && (count != FIFO_DEPTH[LW-1:0]);
        rd_req_ready = rst_n && (state == IDLE) && (count == '0) && !ctl_busy && !wr_req_valid;
        push         = wr_req_valid && wr_req_ready;
        pop          = (state == IDLE) && (count != '0) && !ctl_busy;
        rd_acc       = rd_req_valid && rd_req_ready;
        tmo_hit      = (state == WAIT_BUSY) && !ctl_busy && (tmo_cnt == TW'(BUSY_TMO - 1));
        done         = (state == WAIT_DONE) && !ctl_busy;
        fifo_level   = count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pop || rd_acc) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (ctl_busy) state_nxt = WAIT_DONE;
                       else if (tmo_hit) state_nxt = IDLE;
            WAIT_DONE: if (!ctl_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr[PW-1:0]] <= wr_req_addr;
            fifo_data[wptr[PW-1:0]] <= wr_req_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + LW'(1);
            if (pop)  rptr <= rptr + LW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Enables are registered on leaving ISSUE so they form a clean one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_addr      <= '0;
            ctl_wr_data   <= '0;
            is_rd         <= 1'b0;
            tmo_cnt       <= '0;
            ctl_wr_enable <= 1'b0;
            ctl_rd_enable <= 1'b0;
            tmo_err       <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            ctl_wr_enable <= (state == ISSUE) && !is_rd;
            ctl_rd_enable <= (state == ISSUE) && is_rd;
            rd_resp_valid <= 1'b0;
            if (pop) begin
                ctl_addr    <= fifo_addr[rptr[PW-1:0]];
                ctl_wr_data <= fifo_data[rptr[PW-1:0]];
                is_rd       <= 1'b0;
            end else if (rd_acc) begin
                ctl_addr <= rd_req_addr;
                is_rd    <= 1'b1;
            end
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT_BUSY && !ctl_busy && !tmo_hit)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit)
                tmo_err <= 1'b1;
            if (is_rd && (done || tmo_hit)) begin
                rd_resp_data  <= ctl_rd_data;
                rd_resp_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed bench for sdram_host_bridge with a simple busy-pulse controller model.
module tb_sdram_host_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req_valid, wr_req_ready;
    logic [23:0] wr_req_addr;
    logic [15:0] wr_req_data;
    logic        rd_req_valid, rd_req_ready;
    logic [23:0] rd_req_addr;
    logic        rd_resp_valid;
    logic [15:0] rd_resp_data;
    logic [23:0] ctl_addr;
    logic [15:0] ctl_wr_data;
    logic        ctl_wr_enable, ctl_rd_enable, ctl_busy;
    logic [15:0] ctl_rd_data = 16'h0;
    logic [3:0]  fifo_level;
    logic        tmo_err;

    int total = 0;
    int bad   = 0;

    // controller model state
    logic [7:0]  bcnt = 8'd0;
    logic [7:0]  busy_len = 8'd4;
    logic        hold_busy = 1'b0;
    logic        no_busy = 1'b0;
    logic [15:0] mem [256];
    logic [23:0] log_a [$];
    logic [15:0] log_d [$];
    int          resp_cnt = 0;

    always #5 clk = ~clk;

    assign ctl_busy = hold_busy || (bcnt != 8'd0);

    always @(posedge clk) begin
        if (ctl_wr_enable) begin
            mem[ctl_addr[7:0]] <= ctl_wr_data;
            log_a.push_back(ctl_addr);
            log_d.push_back(ctl_wr_data);
        end
        if (ctl_rd_enable) ctl_rd_data <= mem[ctl_addr[7:0]];
        if ((ctl_wr_enable || ctl_rd_enable) && !no_busy) bcnt <= busy_len;
        else if (bcnt != 8'd0) bcnt <= bcnt - 8'd1;
        if (rd_resp_valid) resp_cnt <= resp_cnt + 1;
    end

    sdram_host_bridge #(.ADDR_W(24), .DATA_W(16), .FIFO_DEPTH(8), .BUSY_TMO(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .ctl_addr(ctl_addr), .ctl_wr_data(ctl_wr_data),
        .ctl_wr_enable(ctl_wr_enable), .ctl_rd_enable(ctl_rd_enable),
        .ctl_busy(ctl_busy), .ctl_rd_data(ctl_rd_data),
        .fifo_level(fifo_level), .tmo_err(tmo_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, errs, r0, w0;
        logic acc, got;
        rst_n = 1'b0; wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0;
        repeat (3) tick();

        // reset state
        chk("rst_level", fifo_level, 0);
        chk("rst_wr_en", ctl_wr_enable, 0);
        chk("rst_rd_en", ctl_rd_enable, 0);
        chk("rst_resp", rd_resp_valid, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_wr_ready", wr_req_ready, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_wr_ready", wr_req_ready, 1);
        chk("post_rst_rd_ready", rd_req_ready, 1);

        // single write, enable 2 cycles after accept
        log_a.delete(); log_d.delete();
        busy_len = 8'd4;
        wr_req_valid = 1'b1; wr_req_addr = 24'h001234; wr_req_data = 16'hBEEF;
        tick();
        wr_req_valid = 1'b0;
        chk("t2_level", fifo_level, 1);
        chk("t2_en_e0", ctl_wr_enable, 0);
        tick();
        chk("t2_en_e1", ctl_wr_enable, 0);
        tick();
        chk("t2_en_e2", ctl_wr_enable, 1);
        chk("t2_addr", ctl_addr, 24'h001234);
        chk("t2_data", ctl_wr_data, 16'hBEEF);
        tick();
        chk("t2_en_e3", ctl_wr_enable, 0);
        repeat (10) tick();
        chk("t2_count", log_a.size(), 1);

        // fill FIFO while controller is held busy
        log_a.delete(); log_d.delete();
        hold_busy = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            wr_req_valid = 1'b1;
            wr_req_addr = 24'h000100 + 24'(n);
            wr_req_data = 16'hA000 + 16'(n);
            chk("t3_ready", wr_req_ready, (i < 8));
            acc = wr_req_ready;
            tick();
            if (acc) n++;
        end
        wr_req_valid = 1'b0;
        chk("t3_full_level", fifo_level, 8);
        chk("t3_no_issue", log_a.size(), 0);
        hold_busy = 1'b0;
        repeat (120) tick();
        chk("t3_count", log_a.size(), 8);
        errs = 0;
        for (int i = 0; i < 8; i++)
            if (i < log_a.size())
                if (log_a[i] != 24'h000100 + 24'(i) || log_d[i] != 16'hA000 + 16'(i)) errs++;
        chk("t3_order", errs, 0);
        chk("t3_level", fifo_level, 0);

        // read after write waits for the FIFO to drain
        log_a.delete(); log_d.delete();
        wr_req_valid = 1'b1; wr_req_addr = 24'h000040; wr_req_data = 16'h5A5A;
        tick();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 24'h000040;
        chk("t4_held", rd_req_ready, 0);
        k = 0;
        while (!rd_req_ready && k < 40) begin tick(); k++; end
        chk("t4_ready_seen", rd_req_ready, 1);
        chk("t4_wait_long", (k > 2), 1);
        chk("t4_wr_done", log_a.size(), 1);
        tick();
        rd_req_valid = 1'b0;
        chk("t4_rd_en_e0", ctl_rd_enable, 0);
        tick();
        chk("t4_rd_en_e1", ctl_rd_enable, 1);
        chk("t4_rd_addr", ctl_addr, 24'h000040);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (rd_resp_valid) got = 1'b1;
        end
        chk("t4_resp_seen", got, 1);
        chk("t4_resp_data", rd_resp_data, 16'h5A5A);
        tick();
        chk("t4_resp_pulse", rd_resp_valid, 0);
        chk("t4_resp_cnt", resp_cnt, 1);

        // push and pop in the same cycle at level 3
        log_a.delete(); log_d.delete();
        hold_busy = 1'b1; busy_len = 8'd2;
        for (int i = 0; i < 3; i++) begin
            wr_req_valid = 1'b1;
            wr_req_addr = 24'h000200 + 24'(i);
            wr_req_data = 16'hC000 + 16'(i);
            tick();
        end
        wr_req_valid = 1'b0;
        chk("t5_level_init", fifo_level, 3);
        hold_busy = 1'b0;
        wr_req_valid = 1'b1; wr_req_addr = 24'h000203; wr_req_data = 16'hC003;
        tick();
        wr_req_valid = 1'b0;
        chk("t5_level_first", fifo_level, 3);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("t5_en", ctl_wr_enable, 1);
            repeat (4) begin
                tick();
                chk("t5_level_wait", fifo_level, 3);
            end
            wr_req_valid = 1'b1;
            wr_req_addr = 24'h000203 + 24'(i);
            wr_req_data = 16'hC003 + 16'(i);
            tick();
            wr_req_valid = 1'b0;
            chk("t5_level_pp", fifo_level, 3);
        end
        repeat (100) tick();
        chk("t5_count", log_a.size(), 23);
        errs = 0;
        for (int i = 0; i < 23; i++)
            if (i < log_a.size())
                if (log_a[i] != 24'h000200 + 24'(i) || log_d[i] != 16'hC000 + 16'(i)) errs++;
        chk("t5_order", errs, 0);

        // busy never rises -> timeout after 64 cycles of waiting
        log_a.delete(); log_d.delete();
        no_busy = 1'b1;
        wr_req_valid = 1'b1; wr_req_addr = 24'h000300; wr_req_data = 16'h1111;
        tick();
        wr_req_valid = 1'b0;
        repeat (65) tick();
        chk("t6_tmo_before", tmo_err, 0);
        tick();
        chk("t6_tmo_set", tmo_err, 1);
        chk("t6_issued", log_a.size(), 1);
        no_busy = 1'b0; busy_len = 8'd4;
        wr_req_valid = 1'b1; wr_req_addr = 24'h000301; wr_req_data = 16'h2222;
        tick();
        wr_req_valid = 1'b0;
        tick();
        chk("t6_en_e1", ctl_wr_enable, 0);
        tick();
        chk("t6_en_e2", ctl_wr_enable, 1);
        chk("t6_addr", ctl_addr, 24'h000301);
        chk("t6_data", ctl_wr_data, 16'h2222);
        repeat (12) tick();
        chk("t6_count", log_a.size(), 2);
        chk("t6_tmo_sticky", tmo_err, 1);

        // reset in the middle of a read's WAIT_DONE
        busy_len = 8'd20;
        rd_req_valid = 1'b1; rd_req_addr = 24'h000040;
        k = 0;
        while (!rd_req_ready && k < 40) begin tick(); k++; end
        chk("t1_rd_ready", rd_req_ready, 1);
        tick();
        rd_req_valid = 1'b0;
        repeat (5) tick();
        chk("t1_busy", ctl_busy, 1);
        wr_req_valid = 1'b1; wr_req_addr = 24'h000050; wr_req_data = 16'h7777;
        tick();
        wr_req_valid = 1'b0;
        chk("t1_level_pre", fifo_level, 1);
        r0 = resp_cnt;
        w0 = log_a.size();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_wr_en", ctl_wr_enable, 0);
        chk("t1_rd_en", ctl_rd_enable, 0);
        chk("t1_resp", rd_resp_valid, 0);
        chk("t1_level", fifo_level, 0);
        chk("t1_tmo", tmo_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("t1_no_resp", resp_cnt, r0);
        chk("t1_no_write", log_a.size(), w0);
        chk("t1_level_after", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
